// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register (univ_shift_reg) and its
// per-bit slice (usr_cell).
//   mode_t    : 2-bit operation select type
//   MODE_HOLD : 2'b00  keep the current contents
//   MODE_SHR  : 2'b01  shift toward bit 0 (new bit enters at the MSB)
//   MODE_SHL  : 2'b10  shift toward the MSB (new bit enters at bit 0)
//   MODE_LOAD : 2'b11  parallel load
// ---------------------------------------------------------------------------
package usr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/usr_cell.sv
// ---------------------------------------------------------------------------
// usr_cell
// One bit slice of the universal shift register: a 4:1 mux selecting the next
// value, feeding a positive-edge flip-flop with asynchronous active-high reset.
// Ports:
//   clk      in  clock, state updates on posedge
//   rst      in  asynchronous active-high reset, clears the bit
//   mode     in  operation select (mode_t)
//   hold_val in  value kept on hold (the slice's own output)
//   left_nb  in  value of the next-higher bit (taken on shift right)
//   right_nb in  value of the next-lower bit (taken on shift left)
//   load_bit in  parallel load data for this bit
//   q_bit    out registered bit
// ---------------------------------------------------------------------------
module usr_cell
  import usr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  mode_t mode,
  input  logic  hold_val,
  input  logic  left_nb,
  input  logic  right_nb,
  input  logic  load_bit,
  output logic  q_bit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_bit <= 1'b0;
    end else begin
      case (mode)
        MODE_SHR:  q_bit <= left_nb;
        MODE_SHL:  q_bit <= right_nb;
        MODE_LOAD: q_bit <= load_bit;
        // MODE_HOLD, and any unknown mode value, keeps the bit
        default:   q_bit <= hold_val;
      endcase
    end
  end

endmodule : usr_cell

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Parameterised 74194-style universal shift register with a shift counter that
// pulses word_done when WIDTH shifts (in any mix of directions) have completed,
// so it doubles as a serial-to-parallel converter.
// Optional build macro: SHIFT_ROTATE_EN -- when defined, the shift modes rotate
// the register and the serial inputs sr_in / sl_in are ignored.
// Parameters:
//   WIDTH      register width, 2..32
// Ports:
//   clk        in  clock, state updates on posedge
//   rst        in  asynchronous active-high reset
//   mode       in  00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d_par      in  parallel load data [WIDTH-1:0]
//   sr_in      in  serial input for shift right, enters at bit WIDTH-1
//   sl_in      in  serial input for shift left, enters at bit 0
//   q          out register contents [WIDTH-1:0]
//   sr_out     out q[0]
//   sl_out     out q[WIDTH-1]
//   word_done  out registered one-cycle pulse after the WIDTH-th shift
// ---------------------------------------------------------------------------
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d_par,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] q,
  output logic             sr_out,
  output logic             sl_out,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Bits entering at the two ends of the register during a shift.
  logic msb_in;
  logic lsb_in;

`ifdef SHIFT_ROTATE_EN
  assign msb_in = q[0];
  assign lsb_in = q[WIDTH-1];
  // Serial inputs stay on the port list for pin compatibility only.
  logic unused_serial;
  assign unused_serial = sr_in ^ sl_in;
`else
  assign msb_in = sr_in;
  assign lsb_in = sl_in;
`endif

  // -------------------------------------------------------------------------
  // Bit slices
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic left_nb;
      logic right_nb;

      if (gi == WIDTH - 1) begin : g_msb
        assign left_nb = msb_in;
      end else begin : g_mid_hi
        assign left_nb = q[gi+1];
      end

      if (gi == 0) begin : g_lsb
        assign right_nb = lsb_in;
      end else begin : g_mid_lo
        assign right_nb = q[gi-1];
      end

      usr_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .hold_val (q[gi]),
        .left_nb  (left_nb),
        .right_nb (right_nb),
        .load_bit (d_par[gi]),
        .q_bit    (q[gi])
      );
    end
  endgenerate

  assign sr_out = q[0];
  assign sl_out = q[WIDTH-1];

  // -------------------------------------------------------------------------
  // Shift counter and word_done pulse
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic             word_done_reg;
  logic             last_shift;

  assign last_shift = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      word_done_reg <= 1'b0;
    end else begin
      case (mode)
        MODE_SHR, MODE_SHL: begin
          // Either direction counts toward the same word.
          if (last_shift) begin
            cnt_reg       <= '0;
            word_done_reg <= 1'b1;
          end else begin
            cnt_reg       <= cnt_reg + CNT_W'(1);
            word_done_reg <= 1'b0;
          end
        end
        MODE_LOAD: begin
          cnt_reg       <= '0;
          word_done_reg <= 1'b0;
        end
        default: begin
          // Hold (or unknown mode): count is kept, pulse ends.
          word_done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign word_done = word_done_reg;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed self-checking bench for univ_shift_reg at WIDTH=4. Builds with or
// without SHIFT_ROTATE_EN; the serial-input scenarios run in the default build
// and the rotate scenario runs when the macro is defined.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d_par;
  logic             sr_in;
  logic             sl_in;
  logic [WIDTH-1:0] q;
  logic             sr_out;
  logic             sl_out;
  logic             word_done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .d_par     (d_par),
    .sr_in     (sr_in),
    .sl_in     (sl_in),
    .q         (q),
    .sr_out    (sr_out),
    .sl_out    (sl_out),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full output check of q, both serial outputs and word_done; one line each.
  task automatic expect_state(input string tag, input logic [WIDTH-1:0] q_exp, input logic wd_exp);
    check({tag, ".q"},         32'(q),         32'(q_exp));
    check({tag, ".sr_out"},    32'(sr_out),    32'(q_exp[0]));
    check({tag, ".sl_out"},    32'(sl_out),    32'(q_exp[WIDTH-1]));
    check({tag, ".word_done"}, 32'(word_done), 32'(wd_exp));
    $display("[%0t] %s q=%b sr_out=%b sl_out=%b word_done=%b",
             $time, tag, q, sr_out, sl_out, word_done);
  endtask

  // Advance one active edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    mode  = MODE_HOLD;
    d_par = '0;
    sr_in = 1'b0;
    sl_in = 1'b0;
    #12;
    expect_state("reset", 4'b0000, 1'b0);
    rst = 1'b0;
    step();

    // ---- parallel load then hold ----
    pulse_rst();
    mode = MODE_LOAD; d_par = 4'b1011;
    step(); expect_state("load", 4'b1011, 1'b0);
    mode = MODE_HOLD; d_par = 4'b0000;
    step(); expect_state("hold1", 4'b1011, 1'b0);
    step(); expect_state("hold2", 4'b1011, 1'b0);
    step(); expect_state("hold3", 4'b1011, 1'b0);

`ifdef SHIFT_ROTATE_EN
    // ---- rotate right: serial input ignored ----
    pulse_rst();
    mode = MODE_LOAD; d_par = 4'b1000;
    step(); expect_state("rot_load", 4'b1000, 1'b0);
    mode = MODE_SHR; sr_in = 1'b0; sl_in = 1'b1;
    step(); expect_state("rot_r1", 4'b0100, 1'b0);
    step(); expect_state("rot_r2", 4'b0010, 1'b0);
    step(); expect_state("rot_r3", 4'b0001, 1'b0);
    step(); expect_state("rot_r4", 4'b1000, 1'b1);
    // ---- rotate left ----
    mode = MODE_SHL; sl_in = 1'b0;
    step(); expect_state("rot_l1", 4'b0001, 1'b0);
    step(); expect_state("rot_l2", 4'b0010, 1'b0);
    mode = MODE_HOLD;
    step(); expect_state("rot_hold", 4'b0010, 1'b0);
`else
    // ---- shift right with serial data ----
    pulse_rst();
    mode = MODE_SHR;
    sr_in = 1'b1; step(); expect_state("shr1", 4'b1000, 1'b0);
    sr_in = 1'b0; step(); expect_state("shr2", 4'b0100, 1'b0);
    sr_in = 1'b0; step(); expect_state("shr3", 4'b0010, 1'b0);
    sr_in = 1'b1; step(); expect_state("shr4", 4'b1001, 1'b1);
    mode = MODE_HOLD;
    step(); expect_state("shr_hold", 4'b1001, 1'b0);

    // ---- shift left then direction change ----
    pulse_rst();
    mode = MODE_SHL; sl_in = 1'b1;
    step(); expect_state("dir1", 4'b0001, 1'b0);
    step(); expect_state("dir2", 4'b0011, 1'b0);
    mode = MODE_SHR; sr_in = 1'b0; sl_in = 1'b0;
    step(); expect_state("dir3", 4'b0001, 1'b0);
    step(); expect_state("dir4", 4'b0000, 1'b1);

    // ---- load clears the count ----
    pulse_rst();
    mode = MODE_SHR; sr_in = 1'b0;
    step(); step(); step();
    mode = MODE_LOAD; d_par = 4'b0110;
    step(); expect_state("ld_cnt_load", 4'b0110, 1'b0);
    mode = MODE_SHR;
    step(); expect_state("ld_cnt_s1", 4'b0011, 1'b0);
    step(); expect_state("ld_cnt_s2", 4'b0001, 1'b0);
    step(); expect_state("ld_cnt_s3", 4'b0000, 1'b0);
    step(); expect_state("ld_cnt_s4", 4'b0000, 1'b1);
    // load right after completion clears word_done
    mode = MODE_LOAD; d_par = 4'b1010;
    step(); expect_state("ld_after_done", 4'b1010, 1'b0);

    // ---- hold mid-word keeps the count ----
    pulse_rst();
    mode = MODE_SHL; sl_in = 1'b1;
    step(); step();
    mode = MODE_HOLD;
    step(); step(); expect_state("hold_mid", 4'b0011, 1'b0);
    mode = MODE_SHL; sl_in = 1'b0;
    step(); expect_state("hold_mid_s3", 4'b0110, 1'b0);
    step(); expect_state("hold_mid_s4", 4'b1100, 1'b1);

    // ---- asynchronous reset mid-word ----
    pulse_rst();
    mode = MODE_SHR; sr_in = 1'b1;
    step(); step(); expect_state("ar_pre", 4'b1100, 1'b0);
    mode = MODE_HOLD;
    rst = 1'b1;
    #1;
    expect_state("ar_async", 4'b0000, 1'b0);
    #1;
    rst = 1'b0;
    mode = MODE_SHR; sr_in = 1'b0;
    step(); expect_state("ar_s1", 4'b0000, 1'b0);
    step(); expect_state("ar_s2", 4'b0000, 1'b0);
    step(); expect_state("ar_s3", 4'b0000, 1'b0);
    step(); expect_state("ar_s4", 4'b0000, 1'b1);
`endif

    mode = MODE_HOLD;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_univ_shift_reg
